speed_gate_emulator: RTL and testbench

Stimulus generator for the two-gate speed-measurement path: the transmit-side counterpart of the speed measurement block. Given a requested display speed code, it computes the sensor_a-to-sensor_b interval the measurer converts back to that code, `N = floor(K / speed_code)`. It then drives a sensor_a pulse, waits exactly N clocks, and drives a sensor_b pulse. It is used for on-board calibration (pin-muxed onto the sensor inputs) and as the stimulus source in the measurer's bench.

---
 rtl/speed_gate_if.sv | 22 ++
 rtl/speed_gate_emulator.sv | 177 +++++++++++++++++
 tb/tb_speed_gate_emulator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/speed_gate_if.sv
// Request/response bundle of the two-gate speed stimulus generator.
// The controller (bench or calibration logic) is the master; the emulator is the slave.
interface speed_gate_if;
  logic        start;
  logic [13:0] speed_code;
  logic        sensor_a;
  logic        sensor_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] ticks;

  modport master (
    output start, speed_code,
    input  sensor_a, sensor_b, busy, done, err, ticks
  );

  modport slave (
    input  start, speed_code,
    output sensor_a, sensor_b, busy, done, err, ticks
  );
endinterface

// File: rtl/speed_gate_emulator.sv
// Emits a sensor_a pulse, waits N = floor(K / speed_code) clocks, then a sensor_b pulse.
// N comes from a bit-serial restoring divider, so the path uses no multiplier or wide divider.
module speed_gate_emulator #(
  parameter int unsigned K        = 36_000_000,
  parameter int unsigned PULSE_W  = 12,
  parameter int unsigned MAX_CODE = 9999
) (
  input  logic        clk,
  input  logic        rst,
  speed_gate_if.slave gate
);

  localparam int unsigned QW = 26;
  localparam int unsigned RW = 15;
  localparam int unsigned DW = 14;
  localparam int unsigned TW = 24;

  localparam logic [QW-1:0] K_VEC    = QW'(K);
  localparam logic [TW-1:0] TICK_MAX = '1;
  localparam logic [TW-1:0] PW       = TW'(PULSE_W);
  localparam logic [DW-1:0] MAXC     = DW'(MAX_CODE);
  localparam logic [4:0]    LAST_BIT = 5'(QW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_LOAD,
    S_PULSE_A,
    S_WAIT,
    S_PULSE_B
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rem_q,   rem_d;
  logic [QW-1:0] quo_q,   quo_d;
  logic [DW-1:0] div_q,   div_d;
  logic [4:0]    step_q,  step_d;
  logic [TW-1:0] cnt_q,   cnt_d;
  logic [TW-1:0] n_q,     n_d;
  logic [TW-1:0] ticks_q, ticks_d;
  logic          sa_q,    sa_d;
  logic          sb_q,    sb_d;
  logic          done_q,  done_d;
  logic          err_q,   err_d;

  logic [RW-1:0] trial;
  logic          fits;
  logic          code_bad;

  function automatic logic [TW-1:0] sat_ticks(input logic [QW-1:0] q);
    if (|q[QW-1:TW]) return TICK_MAX;
    return q[TW-1:0];
  endfunction

  // Remainder stays below the divisor (< 2^14), so its top bit is free to absorb the shift.
  assign trial    = {rem_q[RW-2:0], quo_q[QW-1]};
  assign fits     = (trial >= {1'b0, div_q});
  assign code_bad = (gate.speed_code == '0) || (gate.speed_code > MAXC);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ticks_d = ticks_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gate.start) begin
          if (code_bad) begin
            err_d = 1'b1;
          end else begin
            div_d   = gate.speed_code;
            rem_d   = '0;
            quo_d   = K_VEC;
            step_d  = '0;
            state_d = S_DIV;
          end
        end
      end

      S_DIV: begin
        rem_d  = fits ? (trial - {1'b0, div_q}) : trial;
        quo_d  = {quo_q[QW-2:0], fits};
        step_d = step_q + 5'd1;
        if (step_q == LAST_BIT) state_d = S_LOAD;
      end

      S_LOAD: begin
        ticks_d = sat_ticks(quo_q);
        n_d     = sat_ticks(quo_q);
        cnt_d   = '0;
        state_d = S_PULSE_A;
      end

      // cnt_q holds the number of edges elapsed since the edge that raised sensor_a.
      S_PULSE_A: begin
        if (!sa_q) begin
          sa_d  = 1'b1;
          cnt_d = TW'(1);
        end else begin
          cnt_d = cnt_q + TW'(1);
          if (cnt_q == PW) begin
            sa_d    = 1'b0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == n_q) begin
          sb_d    = 1'b1;
          cnt_d   = TW'(1);
          state_d = S_PULSE_B;
        end
      end

      S_PULSE_B: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == PW) begin
          sb_d    = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      ticks_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ticks_q <= ticks_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gate.sensor_a = sa_q;
  assign gate.sensor_b = sb_q;
  assign gate.busy     = (state_q != S_IDLE);
  assign gate.done     = done_q;
  assign gate.err      = err_q;
  assign gate.ticks    = ticks_q;

endmodule

// File: tb/tb_speed_gate_emulator.sv
// Scoreboard bench for speed_gate_emulator: each accepted request queues its expected
// interval and start edge; the monitor checks timing and ticks when done strobes.
module tb_speed_gate_emulator;

  localparam longint KK = 36_000_000;
  localparam int     PW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  speed_gate_if bus ();

  speed_gate_emulator dut (
    .clk  (clk),
    .rst  (rst),
    .gate (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int e0;
    int ticks;
    int code;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int a_rise = 0, a_w = 0, b_rise = 0;
  int a_cnt = 0, b_cnt = 0;
  logic pa = 1'b0, pb = 1'b0, pdone = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_ticks(input int code);
    longint q;
    q = KK / code;
    if (q > 64'd16777215) q = 64'd16777215;
    return int'(q);
  endfunction

  // Called at a negedge; start is sampled by the following posedge.
  task automatic send(input int code, input bit accept);
    exp_t e;
    bus.start      = 1'b1;
    bus.speed_code = 14'(code);
    if (accept) begin
      e.e0    = cyc + 1;
      e.ticks = model_ticks(code);
      e.code  = code;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start      = 1'b0;
    bus.speed_code = 14'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_timeout", 32'(bus.done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sensor_a"}, 32'(bus.sensor_a), 0);
    check_eq({tag, "_sensor_b"}, 32'(bus.sensor_b), 0);
    check_eq({tag, "_busy"},     32'(bus.busy),     0);
    check_eq({tag, "_done"},     32'(bus.done),     0);
    check_eq({tag, "_err"},      32'(bus.err),      0);
    check_eq({tag, "_ticks"},    32'(bus.ticks),    0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pa = 1'b0; pb = 1'b0; pdone = 1'b0;
      end else begin
        if (bus.sensor_a && !pa) begin a_rise = cyc; a_cnt++; end
        if (!bus.sensor_a && pa) a_w = cyc - a_rise;
        if (bus.sensor_b && !pb) begin b_rise = cyc; b_cnt++; end
        if (bus.done) begin
          check_eq("done_width", 32'(pdone), 0);
          check_eq("sb_depth", 32'(sb.size()), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("ticks",        bus.ticks, 32'(e.ticks));
            check_eq("a_latency",    32'(a_rise - e.e0), 28);
            check_eq("a_to_b",       32'(b_rise - a_rise), 32'(e.ticks));
            check_eq("a_width",      32'(a_w), PW);
            check_eq("b_width",      32'(cyc - b_rise), PW);
            check_eq("b_fall_done",  32'({pb, bus.sensor_b}), 2);
            check_eq("busy_at_done", 32'(bus.busy), 0);
            if (e.code == 1200 || e.code == 3000)
              check_eq("loopback", 32'(KK / (longint'(bus.ticks) - 1)), 32'(e.code));
          end
        end
        pa = bus.sensor_a; pb = bus.sensor_b; pdone = bus.done;
      end
    end
  end

  initial begin : stim
    int a0, b0;
    logic [23:0] held;
    bus.start      = 1'b0;
    bus.speed_code = '0;
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Nominal codes
    send(1200, 1'b1);
    wait_done(31000);
    @(negedge clk);
    send(9999, 1'b1);
    wait_done(4000);

    // Starts during DIV and WAIT are ignored; then a back-to-back request on done
    @(negedge clk);
    a0 = a_cnt; b0 = b_cnt;
    send(9999, 1'b1);
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.speed_code = 14'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    bus.start = 1'b1; bus.speed_code = 14'd2000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(4000);
    send(9999, 1'b1);
    wait_done(4000);
    repeat (50) @(negedge clk);
    check_eq("a_pulse_count", 32'(a_cnt - a0), 2);
    check_eq("b_pulse_count", 32'(b_cnt - b0), 2);
    check_eq("idle_busy", 32'(bus.busy), 0);

    // Rejected codes
    held = bus.ticks;
    a0 = a_cnt;
    send(0, 1'b0);
    check_eq("err_zero", 32'(bus.err), 1);
    check_eq("err_zero_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check_eq("err_zero_clear", 32'(bus.err), 0);
    send(10000, 1'b0);
    check_eq("err_big", 32'(bus.err), 1);
    check_eq("err_big_busy", 32'(bus.busy), 0);
    repeat (40) @(negedge clk);
    check_eq("err_ticks_held", bus.ticks, held);
    check_eq("err_no_sensor", 32'(a_cnt - a0), 0);

    // Large quotients: observe ticks after LOAD, then abort with an async reset mid-WAIT
    send(7, 1'b0);
    repeat (27) @(negedge clk);
    check_eq("ticks_code7", bus.ticks, 5142857);
    repeat (60) @(negedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("midwait_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    send(1, 1'b0);
    repeat (27) @(negedge clk);
    check_eq("ticks_code1_clamp", bus.ticks, 16777215);
    repeat (60) @(negedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("midwait_rst2");
    @(negedge clk);
    #2 rst = 1'b1;

    // Normal operation after reset release
    @(negedge clk);
    send(3000, 1'b1);
    wait_done(13000);

    repeat (5) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
